// File: rtl/npc_lsu_if.sv
// Core request/response channel and memory-bus channel of the npc load/store unit.
// master: core plus memory adapter side; slave: the LSU itself.
interface npc_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_is_store;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic                resp_valid;
  logic [XLEN-1:0]     resp_rdata;
  logic [1:0]          resp_err;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_wmask;
  logic                mem_resp_valid;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/npc_lsu.sv
// Multi-cycle load/store unit: valid/ready request in, variable-latency memory bus out,
// with lane shifting, byte masks, load extension, misalignment and timeout errors.
module npc_lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 255
) (
  input logic      clk,
  input logic      reset,
  npc_lsu_if.slave bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_MAX == 0) ? '0 : CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nxt;

  logic               is_store_q;
  logic               unsigned_q;
  logic [1:0]         size_q;
  logic [OFF_W-1:0]   lane_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [XLEN-1:0]    wdata_q;
  logic [NB-1:0]      wmask_q;
  logic [XLEN-1:0]    rdata_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic [OFF_W-1:0]   lane_in;
  logic               misaligned;
  logic [NB-1:0]      base_mask;
  logic               timeout;
  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    load_val;

  // Request decode: alignment check and byte-enable pattern before lane shift
  always_comb begin
    lane_in    = bus.req_addr[OFF_W-1:0];
    misaligned = 1'b0;
    base_mask  = '0;
    case (bus.req_size)
      2'd0: begin
        misaligned = 1'b0;
        base_mask  = NB'(1);
      end
      2'd1: begin
        misaligned = bus.req_addr[0];
        base_mask  = NB'(3);
      end
      2'd2: begin
        misaligned = |bus.req_addr[1:0];
        base_mask  = NB'(15);
      end
      default: begin
        misaligned = (XLEN == 32) || (|bus.req_addr[2:0]);
        base_mask  = NB'(255);
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    shifted  = bus.mem_rdata >> {lane_q, 3'b000};
    load_val = shifted;
    case (size_q)
      2'd0: begin
        if (unsigned_q) load_val = XLEN'(shifted[7:0]);
        else            load_val = XLEN'($signed(shifted[7:0]));
      end
      2'd1: begin
        if (unsigned_q) load_val = XLEN'(shifted[15:0]);
        else            load_val = XLEN'($signed(shifted[15:0]));
      end
      2'd2: begin
        if (unsigned_q) load_val = XLEN'(shifted[31:0]);
        else            load_val = XLEN'($signed(shifted[31:0]));
      end
      default: load_val = shifted;
    endcase
  end

  assign timeout = (WAIT_MAX != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A response arriving in the timeout cycle wins over the timeout
  always_comb begin
    state_nxt         = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = misaligned ? RESP : REQ;
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = is_store_q;
        if (bus.mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid || timeout) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'd0;
      lane_q     <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 2'd0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q <= bus.req_is_store;
            unsigned_q <= bus.req_unsigned;
            size_q     <= bus.req_size;
            lane_q     <= lane_in;
            mem_addr_q <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q    <= bus.req_wdata << {lane_in, 3'b000};
            wmask_q    <= bus.req_is_store ? (base_mask << lane_in) : '1;
            rdata_q    <= '0;
            err_q      <= misaligned ? 2'd1 : 2'd0;
            wait_cnt   <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            if (!is_store_q) rdata_q <= load_val;
          end else if (timeout) begin
            err_q <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wmask  = wmask_q;

endmodule

// File: tb/tb_npc_lsu.sv
// Scenario bench for npc_lsu (XLEN=32, WAIT_MAX=4): expected responses are queued when a
// request is driven and popped when resp_valid appears.
module tb_npc_lsu;

  logic clk;
  logic reset;

  npc_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

  npc_lsu #(.XLEN(32), .ADDR_W(32), .WAIT_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] bus_data;
    logic [31:0] expect_data;
  } ld_t;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] lane_data;
  } st_t;

  typedef struct packed {
    logic [1:0]  size;
    logic        store;
    logic [31:0] addr;
  } mis_t;

  exp_t sb[$];
  int   compared    = 0;
  int   mismatched  = 0;
  int   resp_count  = 0;
  int   mreq_cycles = 0;
  int   hs_count    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) resp_count++;
    if (bus.mem_req_valid === 1'b1) mreq_cycles++;
    if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) hs_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk_exp(input logic [31:0] r, input logic [1:0] e);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    return x;
  endfunction

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, output int waited);
    waited           = 0;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
  endtask

  task automatic mem_serve(input int ready_delay, input int wait_cycles, input logic [31:0] rdata);
    int n;
    n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (ready_delay) begin
      @(posedge clk);
      #1;
    end
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    repeat (wait_cycles) begin
      @(posedge clk);
      #1;
    end
    bus.mem_rdata      = rdata;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic wait_resp(output logic got, output logic [31:0] rd, output logic [1:0] er,
                           output int cyc);
    got = 1'b0;
    rd  = '0;
    er  = '0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.req_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
    compared++;
    if (bus.resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid);
    end
    compared++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mem_ctrl: got valid=%b we=%b expected 0 0", bus.mem_req_valid, bus.mem_we);
    end
    compared++;
    if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_resp_data: got %h/%0d expected 0/0", bus.resp_rdata, bus.resp_err);
    end
    compared++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wmask !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_mem_data: got %h/%h/%h expected 0/0/0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
  endtask

  task automatic test_load_word();
    int w, cyc, r0;
    logic got;
    logic [31:0] rd;
    logic [1:0] er;
    exp_t e;
    @(posedge clk);
    #1;
    r0 = resp_count;
    sb.push_back(mk_exp(32'hDEADBEEF, 2'd0));
    drive_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, w);
    @(negedge clk);
    compared++;
    if (bus.mem_req_valid !== 1'b1) begin
      mismatched++; $display("[TB] FAIL lw_req_latency: got %b expected 1", bus.mem_req_valid);
    end
    compared++;
    if (bus.mem_addr !== 32'h80000004) begin
      mismatched++; $display("[TB] FAIL lw_mem_addr: got %h expected 80000004", bus.mem_addr);
    end
    compared++;
    if (bus.mem_we !== 1'b0 || bus.mem_wmask !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL lw_we_mask: got we=%b mask=%h expected 0 f", bus.mem_we, bus.mem_wmask);
    end
    mem_serve(0, 3, 32'hDEADBEEF);
    wait_resp(got, rd, er, cyc);
    e = sb.pop_front();
    compared++;
    if (got !== 1'b1) begin
      mismatched++; $display("[TB] FAIL lw_resp: got no resp_valid expected pulse");
    end else begin
      compared++;
      if (rd !== e.rdata) begin
        mismatched++; $display("[TB] FAIL lw_rdata: got %h expected %h", rd, e.rdata);
      end
      compared++;
      if (er !== e.err) begin
        mismatched++; $display("[TB] FAIL lw_err: got %0d expected %0d", er, e.err);
      end
      compared++;
      if (cyc !== 1) begin
        mismatched++; $display("[TB] FAIL lw_resp_delay: got %0d expected 1", cyc);
      end
    end
    @(posedge clk);
    #1;
    compared++;
    if (resp_count - r0 !== 1 || bus.resp_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lw_single_pulse: got %0d pulses expected 1", resp_count - r0);
    end
  endtask

  task automatic test_load_extend();
    ld_t  tab [7];
    int   w, cyc;
    logic got;
    logic [31:0] rd;
    logic [1:0] er;
    exp_t e;
    tab[0] = '{2'd0, 1'b0, 32'h80000003, 32'h80112233, 32'hFFFFFF80};
    tab[1] = '{2'd0, 1'b1, 32'h80000003, 32'h80112233, 32'h00000080};
    tab[2] = '{2'd1, 1'b0, 32'h80000002, 32'h80112233, 32'hFFFF8011};
    tab[3] = '{2'd1, 1'b1, 32'h80000002, 32'h80112233, 32'h00008011};
    tab[4] = '{2'd0, 1'b0, 32'h80000001, 32'h80112233, 32'h00000022};
    tab[5] = '{2'd1, 1'b0, 32'h80000000, 32'h0000F00D, 32'hFFFFF00D};
    tab[6] = '{2'd2, 1'b0, 32'h80000008, 32'h87654321, 32'h87654321};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      sb.push_back(mk_exp(tab[i].expect_data, 2'd0));
      drive_req(1'b0, tab[i].size, tab[i].uns, tab[i].addr, 32'h0, w);
      @(negedge clk);
      compared++;
      if (bus.mem_addr !== (tab[i].addr & 32'hFFFFFFFC)) begin
        mismatched++;
        $display("[TB] FAIL ld%0d_mem_addr: got %h expected %h", i, bus.mem_addr, tab[i].addr & 32'hFFFFFFFC);
      end
      mem_serve(0, i % 3, tab[i].bus_data);
      wait_resp(got, rd, er, cyc);
      e = sb.pop_front();
      compared++;
      if (got !== 1'b1) begin
        mismatched++; $display("[TB] FAIL ld%0d_resp: got no resp_valid expected pulse", i);
      end else begin
        compared++;
        if (rd !== e.rdata || er !== e.err) begin
          mismatched++;
          $display("[TB] FAIL ld%0d_rdata: got %h/%0d expected %h/%0d", i, rd, er, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_store_lanes();
    st_t  tab [5];
    int   w, cyc;
    logic got;
    logic [31:0] rd, bm;
    logic [1:0] er;
    exp_t e;
    tab[0] = '{2'd1, 32'h80000002, 32'h0000ABCD, 4'b1100, 32'hABCD0000};
    tab[1] = '{2'd0, 32'h80000001, 32'h0000005A, 4'b0010, 32'h00005A00};
    tab[2] = '{2'd0, 32'h80000003, 32'h000000C3, 4'b1000, 32'hC3000000};
    tab[3] = '{2'd2, 32'h80000008, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
    tab[4] = '{2'd1, 32'h80000000, 32'h00001234, 4'b0011, 32'h00001234};
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{tab[i].mask[b]}};
      @(posedge clk);
      #1;
      sb.push_back(mk_exp(32'h0, 2'd0));
      drive_req(1'b1, tab[i].size, 1'b0, tab[i].addr, tab[i].wdata, w);
      @(negedge clk);
      compared++;
      if (bus.mem_wmask !== tab[i].mask) begin
        mismatched++; $display("[TB] FAIL st%0d_wmask: got %b expected %b", i, bus.mem_wmask, tab[i].mask);
      end
      compared++;
      if ((bus.mem_wdata & bm) !== tab[i].lane_data) begin
        mismatched++;
        $display("[TB] FAIL st%0d_wdata: got %h expected %h", i, bus.mem_wdata & bm, tab[i].lane_data);
      end
      compared++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== (tab[i].addr & 32'hFFFFFFFC)) begin
        mismatched++;
        $display("[TB] FAIL st%0d_we_addr: got %b/%h expected 1/%h", i, bus.mem_we, bus.mem_addr,
                 tab[i].addr & 32'hFFFFFFFC);
      end
      mem_serve(0, 1, 32'hFFFFFFFF);
      wait_resp(got, rd, er, cyc);
      e = sb.pop_front();
      compared++;
      if (got !== 1'b1) begin
        mismatched++; $display("[TB] FAIL st%0d_resp: got no resp_valid expected pulse", i);
      end else begin
        compared++;
        if (rd !== e.rdata || er !== e.err) begin
          mismatched++;
          $display("[TB] FAIL st%0d_resp_data: got %h/%0d expected %h/%0d", i, rd, er, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    mis_t tab [5];
    int   w, cyc, m0;
    logic got;
    logic [31:0] rd;
    logic [1:0] er;
    exp_t e;
    tab[0] = '{2'd2, 1'b0, 32'h80000006};
    tab[1] = '{2'd1, 1'b0, 32'h80000001};
    tab[2] = '{2'd1, 1'b1, 32'h80000003};
    tab[3] = '{2'd2, 1'b1, 32'h80000002};
    tab[4] = '{2'd3, 1'b0, 32'h80000000};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      m0 = mreq_cycles;
      sb.push_back(mk_exp(32'h0, 2'd1));
      drive_req(tab[i].store, tab[i].size, 1'b0, tab[i].addr, 32'h5555AAAA, w);
      wait_resp(got, rd, er, cyc);
      e = sb.pop_front();
      compared++;
      if (got !== 1'b1 || cyc !== 1) begin
        mismatched++; $display("[TB] FAIL mis%0d_latency: got %0d cycles expected 1", i, cyc);
      end
      compared++;
      if (rd !== e.rdata || er !== e.err) begin
        mismatched++;
        $display("[TB] FAIL mis%0d_resp: got %h/%0d expected %h/%0d", i, rd, er, e.rdata, e.err);
      end
      @(posedge clk);
      #1;
      compared++;
      if (mreq_cycles !== m0) begin
        mismatched++; $display("[TB] FAIL mis%0d_no_bus: got %0d request cycles expected 0", i, mreq_cycles - m0);
      end
    end
  endtask

  task automatic test_req_stall();
    int   w, cyc, h0, m0;
    logic got;
    logic [31:0] rd;
    logic [1:0] er;
    exp_t e;
    @(posedge clk);
    #1;
    h0 = hs_count;
    m0 = mreq_cycles;
    sb.push_back(mk_exp(32'h0, 2'd0));
    drive_req(1'b1, 2'd2, 1'b0, 32'h80000010, 32'h12345678, w);
    bus.mem_rdata      = 32'hBAD0BAD0;
    bus.mem_resp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask}
          !== {1'b1, 1'b1, 32'h80000010, 32'h12345678, 4'hF}) begin
        mismatched++;
        $display("[TB] FAIL stall%0d_stable: got v=%b we=%b %h %h %h expected 1 1 80000010 12345678 f",
                 i, bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
      end
      if (i == 2) begin
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    wait_resp(got, rd, er, cyc);
    e = sb.pop_front();
    compared++;
    if (got !== 1'b1 || rd !== e.rdata || er !== e.err) begin
      mismatched++;
      $display("[TB] FAIL stall_resp: got %b %h/%0d expected 1 %h/%0d", got, rd, er, e.rdata, e.err);
    end
    @(posedge clk);
    #1;
    compared++;
    if (hs_count - h0 !== 1 || mreq_cycles - m0 !== 6) begin
      mismatched++;
      $display("[TB] FAIL stall_single_req: got %0d handshakes %0d cycles expected 1 6",
               hs_count - h0, mreq_cycles - m0);
    end
  endtask

  task automatic test_timeout();
    int   w, cyc;
    logic got;
    logic [31:0] rd;
    logic [1:0] er;
    exp_t e;
    @(posedge clk);
    #1;
    sb.push_back(mk_exp(32'h0, 2'd2));
    drive_req(1'b0, 2'd2, 1'b0, 32'h80000040, 32'h0, w);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    wait_resp(got, rd, er, cyc);
    e = sb.pop_front();
    compared++;
    if (got !== 1'b1 || cyc !== 5) begin
      mismatched++; $display("[TB] FAIL timeout_delay: got %b after %0d cycles expected 1 after 5", got, cyc);
    end
    compared++;
    if (rd !== e.rdata || er !== e.err) begin
      mismatched++;
      $display("[TB] FAIL timeout_resp: got %h/%0d expected %h/%0d", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_in_wait();
    int w, r0;
    @(posedge clk);
    #1;
    drive_req(1'b0, 2'd2, 1'b0, 32'h80000050, 32'h0, w);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    r0    = resp_count;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_wait_idle: got ready=%b resp=%b mreq=%b expected 1 0 0",
               bus.req_ready, bus.resp_valid, bus.mem_req_valid);
    end
    compared++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wmask !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_wait_clear: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wmask);
    end
    bus.mem_rdata      = 32'h13579BDF;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    compared++;
    if (resp_count !== r0 || bus.req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_wait_no_resp: got %0d pulses ready=%b expected 0 1", resp_count - r0, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] bdata [3];
    logic [31:0] expd  [3];
    logic [1:0]  sizes [3];
    int   w, cyc;
    logic got;
    logic [31:0] rd;
    logic [1:0] er;
    exp_t e;
    addrs[0] = 32'h80000060; bdata[0] = 32'h11111111; expd[0] = 32'h11111111; sizes[0] = 2'd2;
    addrs[1] = 32'h80000064; bdata[1] = 32'h22222222; expd[1] = 32'h22222222; sizes[1] = 2'd2;
    addrs[2] = 32'h80000066; bdata[2] = 32'h8001BEEF; expd[2] = 32'hFFFF8001; sizes[2] = 2'd1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk_exp(expd[i], 2'd0));
      drive_req(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, w);
      if (i > 0) begin
        compared++;
        if (w !== 1) begin
          mismatched++; $display("[TB] FAIL b2b%0d_accept: got %0d cycles after resp expected 1", i, w);
        end
      end
      compared++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== (addrs[i] & 32'hFFFFFFFC)) begin
        mismatched++;
        $display("[TB] FAIL b2b%0d_req: got %b/%h expected 1/%h", i, bus.mem_req_valid, bus.mem_addr,
                 addrs[i] & 32'hFFFFFFFC);
      end
      mem_serve(0, 0, bdata[i]);
      wait_resp(got, rd, er, cyc);
      e = sb.pop_front();
      compared++;
      if (got !== 1'b1 || rd !== e.rdata || er !== e.err) begin
        mismatched++;
        $display("[TB] FAIL b2b%0d_resp: got %b %h/%0d expected 1 %h/%0d", i, got, rd, er, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_is_store   = 1'b0;
    bus.req_size       = 2'd0;
    bus.req_unsigned   = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_lanes();
    test_misaligned();
    test_req_stall();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
